tern_word_decoder: RTL and testbench



---
 rtl/tern_word_decoder.sv | 94 +++++++++
 tb/tb_tern_word_decoder.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tern_word_decoder.sv
// Sequential ternary-to-binary decoder: accepts one NTRITS-trit word, folds it
// MSB-first into a binary accumulator at one trit per clock, flags 11 codes.
module tern_word_decoder #(
    parameter int NTRITS = 6,
    parameter int OUT_W  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2*NTRITS-1:0]   in_word,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_W-1:0]      out_value,
    output logic                  out_err
);

    localparam int IDX_W = (NTRITS > 1) ? $clog2(NTRITS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [2*NTRITS-1:0] sh_q, sh_d;
    logic [OUT_W-1:0]    acc_q, acc_d;
    logic                err_q, err_d;
    logic [IDX_W-1:0]    idx_q, idx_d;

    logic [1:0]          trit;
    logic [OUT_W-1:0]    trit_val;

    // The word is shifted left each step, so the current trit is always the top pair.
    assign trit     = sh_q[2*NTRITS-1 -: 2];
    assign trit_val = (trit == 2'b11) ? '0 : OUT_W'(trit);

    always_comb begin
        // NOTE: every _d defaults to its _q first so no path leaves a signal unassigned (no latches).
        state_d = state_q;
        sh_d    = sh_q;
        acc_d   = acc_q;
        err_d   = err_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sh_d    = in_word;
                    acc_d   = '0;
                    err_d   = 1'b0;
                    idx_d   = IDX_W'(NTRITS - 1);
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                acc_d = acc_q + (acc_q << 1) + trit_val;
                err_d = err_q | (trit == 2'b11);
                sh_d  = sh_q << 2;
                idx_d = idx_q - IDX_W'(1);
                if (idx_q == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state_q <= S_IDLE;
            sh_q    <= '0;
            acc_q   <= '0;
            err_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            acc_q   <= acc_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out_value = acc_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_tern_word_decoder.sv
// Self-checking bench for tern_word_decoder: directed and random words checked
// against a positional-weight reference model, plus handshake timing checks.
module tb_tern_word_decoder;

    localparam int N = 6;
    localparam int W = 10;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [2*N-1:0] in_word;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_value;
    logic           out_err;

    int total = 0;
    int bad   = 0;

    tern_word_decoder #(.NTRITS(N), .OUT_W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_value (out_value),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Build a word from six trit codes, MSB first (3 means code 11).
    function automatic logic [2*N-1:0] w6(input int t5, input int t4, input int t3,
                                          input int t2, input int t1, input int t0);
        return {t5[1:0], t4[1:0], t3[1:0], t2[1:0], t1[1:0], t0[1:0]};
    endfunction

    // Reference: value = sum of digit * 3^position, code 11 counts 0 and sets err.
    task automatic model(input logic [2*N-1:0] w, output int v, output bit e);
        int p;
        int d;
        v = 0;
        e = 1'b0;
        p = 1;
        for (int i = 0; i < N; i++) begin
            d = int'(w[2*i +: 2]);
            if (d == 3) begin
                e = 1'b1;
                d = 0;
            end
            v = v + d * p;
            p = p * 3;
        end
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s wait_ready: in_ready=%b expected=1", name, in_ready);
        end
    endtask

    // Send one word with out_ready high and check value, flag, latency and release.
    task automatic run_word(input logic [2*N-1:0] w, input string name);
        int v;
        bit e;
        int lat;
        model(w, v, e);
        out_ready = 1'b1;
        wait_ready(name);
        in_word  = w;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL %s busy: in_ready=%b expected=0", name, in_ready);
        end
        lat = 0;
        while (!out_valid && lat < 50) begin
            step();
            lat++;
        end
        total++;
        if (lat != N) begin
            bad++;
            $display("FAIL %s latency: got=%0d expected=%0d", name, lat, N);
        end
        total++;
        if (out_value !== v[W-1:0]) begin
            bad++;
            $display("FAIL %s value: got=%0d expected=%0d (word=%h)", name, out_value, v, w);
        end
        total++;
        if (out_err !== e) begin
            bad++;
            $display("FAIL %s err: got=%b expected=%b (word=%h)", name, out_err, e, w);
        end
        step();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s release: out_valid=%b in_ready=%b expected 0/1",
                     name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_word   = w6(2, 2, 2, 2, 2, 2);
        out_ready = 1'b1;
        repeat (3) step();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_value !== '0 || out_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b out_value=%0d out_err=%b expected 1/0/0/0",
                     in_ready, out_valid, out_value, out_err);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        step();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_no_accept: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_basic();
        run_word(w6(0, 0, 0, 0, 0, 1), "basic_000001");
        run_word(w6(2, 2, 2, 2, 2, 2), "basic_222222");
        run_word(w6(1, 0, 2, 0, 1, 2), "basic_102012");
    endtask

    task automatic test_invalid();
        run_word(w6(3, 0, 0, 0, 0, 1), "invalid_code");
        run_word(w6(0, 0, 0, 0, 0, 2), "err_cleared");
    endtask

    task automatic test_random();
        logic [2*N-1:0] w;
        for (int i = 0; i < 20; i++) begin
            w = (2*N)'($urandom);
            run_word(w, $sformatf("random_%0d", i));
        end
    endtask

    task automatic test_backpressure();
        logic [2*N-1:0] w;
        int v;
        bit e;
        int n;
        logic [W-1:0] held_val;
        logic         held_err;
        w = w6(2, 1, 3, 0, 2, 1);
        model(w, v, e);
        out_ready = 1'b0;
        wait_ready("backpressure");
        in_word  = w;
        in_valid = 1'b1;
        step();
        n = 0;
        while (!out_valid && n < 50) begin
            in_valid = 1'($urandom);
            in_word  = (2*N)'($urandom);
            step();
            n++;
        end
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL bp_done_timeout: out_valid=%b expected=1", out_valid);
        end
        held_val = out_value;
        held_err = out_err;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'($urandom);
            in_word  = (2*N)'($urandom);
            step();
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_value !== held_val || out_err !== held_err) begin
                bad++;
                $display("FAIL bp_stable_%0d: out_valid=%b in_ready=%b value=%0d err=%b expected 1/0/%0d/%b",
                         k, out_valid, in_ready, out_value, out_err, held_val, held_err);
            end
        end
        total++;
        if (out_value !== v[W-1:0] || out_err !== e) begin
            bad++;
            $display("FAIL bp_result: value=%0d err=%b expected %0d/%b", out_value, out_err, v, e);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [2*N-1:0] wa;
        logic [2*N-1:0] wb;
        int va, vb;
        bit ea, eb;
        int b_acc;
        logic ir;
        int           pk[$];
        logic [W-1:0] pv[$];
        logic         pe[$];
        wa = w6(1, 2, 0, 1, 1, 0);
        wb = w6(0, 2, 3, 1, 0, 2);
        model(wa, va, ea);
        model(wb, vb, eb);
        out_ready = 1'b1;
        wait_ready("b2b");
        in_word  = wa;
        in_valid = 1'b1;
        step();
        in_word = wb;
        b_acc   = -1;
        for (int k = 1; k <= 18; k++) begin
            ir = in_ready;
            step();
            if (ir && in_valid && b_acc < 0) begin
                b_acc    = k;
                in_valid = 1'b0;
            end
            if (out_valid) begin
                pk.push_back(k);
                pv.push_back(out_value);
                pe.push_back(out_err);
            end
        end
        in_valid = 1'b0;
        total++;
        if (b_acc != N + 2) begin
            bad++;
            $display("FAIL b2b_spacing: got=%0d expected=%0d", b_acc, N + 2);
        end
        total++;
        if (pk.size() != 2) begin
            bad++;
            $display("FAIL b2b_pulse_count: got=%0d expected=2", pk.size());
        end else begin
            total++;
            if (pk[0] != N || pv[0] !== va[W-1:0] || pe[0] !== ea) begin
                bad++;
                $display("FAIL b2b_word_a: cycle=%0d value=%0d err=%b expected %0d/%0d/%b",
                         pk[0], pv[0], pe[0], N, va, ea);
            end
            total++;
            if (pk[1] != 2*N + 2 || pv[1] !== vb[W-1:0] || pe[1] !== eb) begin
                bad++;
                $display("FAIL b2b_word_b: cycle=%0d value=%0d err=%b expected %0d/%0d/%b",
                         pk[1], pv[1], pe[1], 2*N + 2, vb, eb);
            end
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        out_ready = 1'b1;
        wait_ready("reset_mid");
        in_word  = w6(2, 2, 1, 1, 0, 0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_value !== '0 || out_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_state: in_ready=%b out_valid=%b value=%0d err=%b expected 1/0/0/0",
                     in_ready, out_valid, out_value, out_err);
        end
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (out_valid) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL reset_mid_discard: out_valid cycles=%0d expected=0", seen);
        end
        run_word(w6(0, 0, 0, 0, 1, 0), "after_reset_000010");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_invalid();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
